// File: rtl/req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the request arbiter slice.
//   - State encodings as plain localparams so older code that compares raw
//     2-bit values still lines up with the enum below.
//   - arb_state_t: the three arbiter FSM states.
//   - id_width(): index width needed to address n requesters (minimum 1).
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    GAP   = ST_GAP
  } arb_state_t;

  // A single requester still needs a 1-bit index so gnt_id is never zero-width.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// ---------------------------------------------------------------------------
// req_arbiter_if
// Bundles the requester-facing signals of req_arbiter.
//   req        requester -> arbiter  request vector, one bit per requester
//   done       requester -> arbiter  current owner has finished
//   gnt        arbiter -> requester  one-hot grant
//   gnt_id     arbiter -> requester  index of current owner (0 when idle)
//   gnt_valid  arbiter -> requester  a grant is active
//   timeout    arbiter -> requester  one-cycle pulse on forced release
// Modports:
//   master  the requester side (drives req/done)
//   slave   the arbiter side (drives the grant outputs)
// ---------------------------------------------------------------------------
interface req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) ();

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/req_arbiter_rr_prio_enc.sv
// ---------------------------------------------------------------------------
// rr_prio_enc
// Combinational rotating-base priority encoder.
// Scans req starting at index base and wrapping modulo N_REQ; the first set
// bit wins.
//   req        in   N_REQ  request vector
//   base       in   ID_W   index that gets highest priority this cycle
//   win_id     out  ID_W   winning index (0 when nothing is requested)
//   win_valid  out  1      at least one request bit is set
// ---------------------------------------------------------------------------
module rr_prio_enc
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  base,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);

  logic [N_REQ-1:0] rotated;
  int               base_i;
  int               low_idx;

  // Rotate right by base so the base requester lands at position 0; this
  // lets a plain lowest-index-first encoder implement the rotating priority.
  always_comb begin
    rotated = '0;
    base_i  = int'(base);
    for (int i = 0; i < N_REQ; i++) begin
      rotated[i] = req[(i + base_i) % N_REQ];
    end
  end

  // Lowest-index-first encoder on the rotated vector, then undo the rotation
  // by adding base back modulo N_REQ.
  always_comb begin
    win_valid = 1'b0;
    low_idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        win_valid = 1'b1;
        low_idx   = i;
      end
    end
    win_id = win_valid ? ID_W'((low_idx + base_i) % N_REQ) : '0;
  end

endmodule

// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter
// Shares one downstream resource between N_REQ requesters. A winner is
// chosen in IDLE with a rotating-base priority encoder, holds a registered
// one-hot grant in GRANT until it signals done, drops its request, or runs
// into the MAX_HOLD limit, and is followed by one dead GAP cycle so two
// owners are never back to back.
// Parameters:
//   N_REQ     number of requesters (2..16)
//   ID_W      grant index width
//   MAX_HOLD  maximum grant length in cycles (>= 2)
//   RR_EN     1 = round-robin base pointer, 0 = fixed priority (req[0] first)
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    req_arbiter_if.slave: req/done in, gnt/gnt_id/gnt_valid/timeout out
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = id_width(N_REQ),
  parameter int MAX_HOLD = 16,
  parameter int RR_EN    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  req_arbiter_if.slave bus
);

  localparam int HOLD_W = id_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state;
  logic [N_REQ-1:0]  gnt_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic              gnt_valid_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ID_W-1:0]   rr_ptr;

  logic [ID_W-1:0]   win_id;
  logic              win_valid;

  logic              owner_req;
  logic              at_limit;
  logic              release_now;
  logic              forced_release;
  logic [ID_W-1:0]   next_ptr;

  rr_prio_enc #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_enc (
    .req       (bus.req),
    .base      (rr_ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Release conditions while granting. A forced release only counts as a
  // timeout when the owner neither finished nor walked away in that cycle.
  always_comb begin
    owner_req      = bus.req[gnt_id_q];
    at_limit       = (hold_cnt == HOLD_LAST);
    release_now    = bus.done || !owner_req || at_limit;
    forced_release = at_limit && !bus.done && owner_req;
    next_ptr       = '0;
    if (RR_EN != 0) begin
      next_ptr = ID_W'((int'(gnt_id_q) + 1) % N_REQ);
    end
  end

  // FSM plus output registers. timeout defaults low so it can only ever be
  // a single-cycle pulse on entry to GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state       <= GRANT;
            gnt_q       <= N_REQ'(1) << win_id;
            gnt_id_q    <= win_id;
            gnt_valid_q <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= GAP;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= forced_release;
            hold_cnt    <= '0;
            rr_ptr      <= next_ptr;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          gnt_q       <= '0;
          gnt_id_q    <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_arbiter
// Directed bench for req_arbiter. Two instances share clock and reset: one
// round-robin (RR_EN=1) and one fixed-priority (RR_EN=0), both N_REQ=4,
// MAX_HOLD=16. Inputs change and outputs are sampled 1ns after the rising
// edge.
// ---------------------------------------------------------------------------
module tb_req_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  req_arbiter_if #(.N_REQ(4), .ID_W(2)) bus_rr ();
  req_arbiter_if #(.N_REQ(4), .ID_W(2)) bus_fp ();

  req_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(16), .RR_EN(1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  req_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(16), .RR_EN(0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_rr.req  = '0;
    bus_rr.done = 1'b0;
    bus_fp.req  = '0;
    bus_fp.done = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reset clears outputs asynchronously mid-grant and also clears rr_ptr.
  task automatic test_reset();
    do_reset();
    bus_rr.req = 4'b0010;
    tick();
    bus_rr.done = 1'b1;
    tick();
    bus_rr.done = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0010)
      $display("[TB] FAIL reset_pregrant: gnt=%b required %b", bus_rr.gnt, 4'b0010);
    else passed++;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_rr.gnt !== 4'b0000 || bus_rr.gnt_valid !== 1'b0 || bus_rr.gnt_id !== 2'd0 || bus_rr.timeout !== 1'b0)
      $display("[TB] FAIL reset_async: gnt=%b valid=%b id=%0d to=%b required 0000/0/0/0",
               bus_rr.gnt, bus_rr.gnt_valid, bus_rr.gnt_id, bus_rr.timeout);
    else passed++;
    bus_rr.req = 4'b1010;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0010 || bus_rr.gnt_id !== 2'd1)
      $display("[TB] FAIL reset_rrptr: gnt=%b id=%0d required 0010/1", bus_rr.gnt, bus_rr.gnt_id);
    else passed++;
  endtask

  // One request, one-cycle latency, done releases through GAP to IDLE.
  task automatic test_single();
    do_reset();
    bus_rr.req = 4'b0100;
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0100 || bus_rr.gnt_id !== 2'd2 || bus_rr.gnt_valid !== 1'b1)
      $display("[TB] FAIL single_grant: gnt=%b id=%0d valid=%b required 0100/2/1",
               bus_rr.gnt, bus_rr.gnt_id, bus_rr.gnt_valid);
    else passed++;
    bus_rr.done = 1'b1;
    bus_rr.req  = 4'b0000;
    tick();
    bus_rr.done = 1'b0;
    checks++;
    if (bus_rr.gnt !== 4'b0000 || bus_rr.gnt_valid !== 1'b0 || bus_rr.timeout !== 1'b0)
      $display("[TB] FAIL single_gap: gnt=%b valid=%b to=%b required 0000/0/0",
               bus_rr.gnt, bus_rr.gnt_valid, bus_rr.timeout);
    else passed++;
    tick();
    tick();
    checks++;
    if (bus_rr.gnt_valid !== 1'b0 || bus_rr.gnt_id !== 2'd0)
      $display("[TB] FAIL single_idle: valid=%b id=%0d required 0/0", bus_rr.gnt_valid, bus_rr.gnt_id);
    else passed++;
  endtask

  // All four requesting: grants rotate 0,1,2,3,0 with a dead cycle between.
  task automatic test_round_robin();
    int         exp_order [5];
    logic [1:0] e;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    bus_rr.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      e = 2'(exp_order[k]);
      checks++;
      if (bus_rr.gnt_id !== e || bus_rr.gnt !== (4'b0001 << e))
        $display("[TB] FAIL rr_order[%0d]: id=%0d gnt=%b required id %0d", k, bus_rr.gnt_id, bus_rr.gnt, e);
      else passed++;
      bus_rr.done = 1'b1;
      tick();
      bus_rr.done = 1'b0;
      checks++;
      if (bus_rr.gnt !== 4'b0000)
        $display("[TB] FAIL rr_gap[%0d]: gnt=%b required 0000", k, bus_rr.gnt);
      else passed++;
      tick();
      tick();
    end
  endtask

  // Fixed priority: requester 1 always beats requester 3.
  task automatic test_fixed_priority();
    do_reset();
    bus_fp.req = 4'b1010;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus_fp.gnt_id !== 2'd1 || bus_fp.gnt !== 4'b0010)
        $display("[TB] FAIL fp_grant[%0d]: id=%0d gnt=%b required 1/0010", k, bus_fp.gnt_id, bus_fp.gnt);
      else passed++;
      bus_fp.done = 1'b1;
      tick();
      bus_fp.done = 1'b0;
      tick();
      tick();
    end
    bus_fp.req = 4'b0000;
  endtask

  // Persistent owner with no done: 16 grant cycles, timeout pulse, re-grant.
  task automatic test_hold_limit();
    int n;
    do_reset();
    bus_rr.req = 4'b0001;
    tick();
    n = 0;
    while (bus_rr.gnt_valid === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16)
      $display("[TB] FAIL hold_len: grant lasted %0d cycles required 16", n);
    else passed++;
    checks++;
    if (bus_rr.timeout !== 1'b1 || bus_rr.gnt !== 4'b0000)
      $display("[TB] FAIL hold_timeout: to=%b gnt=%b required 1/0000", bus_rr.timeout, bus_rr.gnt);
    else passed++;
    tick();
    checks++;
    if (bus_rr.timeout !== 1'b0)
      $display("[TB] FAIL hold_pulse: to=%b required 0", bus_rr.timeout);
    else passed++;
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0001 || bus_rr.gnt_id !== 2'd0)
      $display("[TB] FAIL hold_regrant: gnt=%b id=%0d required 0001/0", bus_rr.gnt, bus_rr.gnt_id);
    else passed++;
  endtask

  // done arriving in the last allowed cycle is a normal release.
  task automatic test_done_at_limit();
    do_reset();
    bus_rr.req = 4'b0001;
    tick();
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (bus_rr.gnt !== 4'b0001)
      $display("[TB] FAIL limit_still_granted: gnt=%b required 0001", bus_rr.gnt);
    else passed++;
    bus_rr.done = 1'b1;
    tick();
    bus_rr.done = 1'b0;
    checks++;
    if (bus_rr.timeout !== 1'b0 || bus_rr.gnt !== 4'b0000)
      $display("[TB] FAIL limit_done: to=%b gnt=%b required 0/0000", bus_rr.timeout, bus_rr.gnt);
    else passed++;
    bus_rr.req = 4'b0000;
  endtask

  // Owner 3 drops its request; pending requester 1 follows two cycles later.
  task automatic test_request_drop();
    do_reset();
    bus_rr.req = 4'b1000;
    tick();
    bus_rr.req = 4'b1010;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (bus_rr.gnt !== 4'b1000 || bus_rr.gnt_id !== 2'd3)
      $display("[TB] FAIL drop_owner: gnt=%b id=%0d required 1000/3", bus_rr.gnt, bus_rr.gnt_id);
    else passed++;
    bus_rr.req = 4'b0010;
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0000 || bus_rr.timeout !== 1'b0)
      $display("[TB] FAIL drop_release: gnt=%b to=%b required 0000/0", bus_rr.gnt, bus_rr.timeout);
    else passed++;
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0000)
      $display("[TB] FAIL drop_idle: gnt=%b required 0000", bus_rr.gnt);
    else passed++;
    tick();
    checks++;
    if (bus_rr.gnt !== 4'b0010 || bus_rr.gnt_id !== 2'd1)
      $display("[TB] FAIL drop_next: gnt=%b id=%0d required 0010/1", bus_rr.gnt, bus_rr.gnt_id);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus_rr.req  = '0;
    bus_rr.done = 1'b0;
    bus_fp.req  = '0;
    bus_fp.done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_hold_limit();
    test_done_at_limit();
    test_request_drop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
